// File: rtl/sddr_init_seq.sv
// DDR3 power-up sequencer: drives the reset-control register (0x0000) of the sddr
// control bus through four timed write steps, with ack-timeout protection.
module sddr_init_seq #(
  parameter int unsigned RESET_HOLD_CYCLES  = 10000,
  parameter int unsigned CKE_WAIT_CYCLES    = 25000,
  parameter int unsigned POST_CKE_CYCLES    = 16,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] FINAL_WORD         = 32'h0000_002B
) (
  input  logic        cpu_clock_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  step_o,
  output logic        ctrl_cmd_valid,
  output logic [15:0] ctrl_cmd_address,
  output logic [31:0] ctrl_cmd_data,
  output logic        ctrl_cmd_write,
  input  logic        ctrl_cmd_ack,
  input  logic        ctrl_rsp_ready,
  input  logic [31:0] ctrl_rsp_data
);

  localparam int unsigned HOLD_N   = (RESET_HOLD_CYCLES == 0) ? 1 : RESET_HOLD_CYCLES;
  localparam int unsigned CKE_N    = (CKE_WAIT_CYCLES == 0) ? 1 : CKE_WAIT_CYCLES;
  localparam int unsigned POST_N   = (POST_CKE_CYCLES == 0) ? 1 : POST_CKE_CYCLES;
  localparam int unsigned TMO_N    = (ACK_TIMEOUT_CYCLES == 0) ? 1 : ACK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_HC   = (HOLD_N > CKE_N) ? HOLD_N : CKE_N;
  localparam int unsigned MAX_WAIT = (MAX_HC > POST_N) ? MAX_HC : POST_N;
  localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam int unsigned TMO_W    = $clog2(TMO_N + 1);
  localparam int unsigned STEP_W   = 2;

  localparam logic [WAIT_W-1:0] HOLD_LD   = WAIT_W'(HOLD_N);
  localparam logic [WAIT_W-1:0] CKE_LD    = WAIT_W'(CKE_N);
  localparam logic [WAIT_W-1:0] POST_LD   = WAIT_W'(POST_N);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_N - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETTLE, S_WAIT, S_DONE, S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                valid_q, valid_d;
  logic [31:0]         data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                to_error;

  // Register value written at each step: ddr/phy reset release, then cke+odt path.
  function automatic logic [31:0] step_word(input logic [STEP_W-1:0] s);
    case (s)
      2'd0:    step_word = 32'h0000_0000;
      2'd1:    step_word = 32'h0000_0003;
      2'd2:    step_word = 32'h0000_0023;
      default: step_word = FINAL_WORD;
    endcase
  endfunction

  function automatic logic [WAIT_W-1:0] wait_load(input logic [STEP_W-1:0] s);
    case (s)
      2'd0:    wait_load = HOLD_LD;
      2'd1:    wait_load = CKE_LD;
      default: wait_load = POST_LD;
    endcase
  endfunction

  always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      wait_q  <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    wait_d   = wait_q;
    tmo_d    = tmo_q;
    valid_d  = valid_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    to_error = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_REQ;
          step_d  = '0;
          data_d  = step_word('0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          tmo_d   = '0;
        end
      end
      S_REQ: begin
        if (ctrl_cmd_ack) begin
          state_d = S_SETTLE;
          valid_d = 1'b0;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          to_error = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      // Ack re-rising means the responder's clock crossing has finished.
      S_SETTLE: begin
        if (ctrl_cmd_ack) begin
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
            wait_d  = wait_load(step_q);
          end
        end else if (tmo_q == TMO_LAST) begin
          to_error = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WAIT: begin
        if (wait_q <= WAIT_W'(1)) begin
          state_d = S_REQ;
          step_d  = step_q + STEP_W'(1);
          data_d  = step_word(step_q + STEP_W'(1));
          valid_d = 1'b1;
          tmo_d   = '0;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (to_error) begin
      state_d = S_ERROR;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      error_d = 1'b1;
    end
  end

  logic unused_rsp_c;
  assign unused_rsp_c = ^{ctrl_rsp_ready, ctrl_rsp_data};

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign step_o           = step_q;
  assign ctrl_cmd_valid   = valid_q;
  assign ctrl_cmd_address = 16'h0000;
  assign ctrl_cmd_data    = data_q;
  assign ctrl_cmd_write   = valid_q;

endmodule

// File: tb/tb_sddr_init_seq.sv
// Bench for sddr_init_seq: reactive responder with programmable ack delays, a timing
// reference model feeding a scoreboard, and a monitor that checks every request/termination.
module tb_sddr_init_seq;

  localparam int HOLD = 5;
  localparam int CKE  = 7;
  localparam int POST = 3;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        ack = 1'b1;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data = '0;
  logic        busy, done, err, valid, write;
  logic [1:0]  step;
  logic [15:0] addr;
  logic [31:0] data;

  sddr_init_seq #(
    .RESET_HOLD_CYCLES (HOLD),
    .CKE_WAIT_CYCLES   (CKE),
    .POST_CKE_CYCLES   (POST),
    .ACK_TIMEOUT_CYCLES(TMO),
    .FINAL_WORD        (32'h0000_002B)
  ) dut (
    .cpu_clock_i     (clk),
    .reset_n_i       (rst_n),
    .start_i         (start_i),
    .busy_o          (busy),
    .done_o          (done),
    .error_o         (err),
    .step_o          (step),
    .ctrl_cmd_valid  (valid),
    .ctrl_cmd_address(addr),
    .ctrl_cmd_data   (data),
    .ctrl_cmd_write  (write),
    .ctrl_cmd_ack    (ack),
    .ctrl_rsp_ready  (rsp_ready),
    .ctrl_rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] data; int step; } req_t;
  typedef struct { int cyc; bit is_err; int step; } term_t;

  req_t        exp_q[$];
  term_t       term_q[$];
  logic [31:0] exp_w[$];
  logic [31:0] cap_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          a_cfg[4];
  int          d_cfg[4];
  logic [31:0] words[4];
  int          waits[3] = '{HOLD, CKE, POST};
  int          start_cnt = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Responder: ack low for a_cfg cycles of each request, low for d_cfg cycles after each transfer.
  int   rsp_seen = 0;
  int   rsp_idx = 0;
  int   req_age = 0;
  int   post_age = 1000;
  logic rsp_prev_valid = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      if (!rsp_prev_valid) begin
        if (rsp_seen != start_cnt) begin
          rsp_idx  = 0;
          rsp_seen = start_cnt;
        end else begin
          rsp_idx = (rsp_idx + 1) % 4;
        end
        req_age = 0;
      end
      req_age++;
      ack = (req_age > a_cfg[rsp_idx]);
    end else begin
      if (rsp_prev_valid) post_age = 0;
      if (post_age < 1000) post_age++;
      ack = (post_age > d_cfg[rsp_idx]);
    end
    rsp_prev_valid = valid;
  end

  // Monitor: pops the scoreboard on every request rise and every done/error rise.
  logic        pv = 1'b0, pdone = 1'b0, perr = 1'b0;
  logic [31:0] pd = '0, cur_data = '0;
  req_t        me;
  term_t       mt;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n) begin
        if (pv && ack) cap_q.push_back(pd);
        if (valid && !pv) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_request: got data %0h want none (cycle %0d)", data, cyc);
          end else begin
            me = exp_q.pop_front();
            chk("req_cycle", 64'(cyc), 64'(me.cyc));
            chk("req_data", 64'(data), 64'(me.data));
            chk("req_step", 64'(step), 64'(me.step));
            chk("req_write_addr", 64'({write, addr}), 64'(17'h1_0000));
            chk("req_busy", 64'(busy), 64'(1));
            cur_data = me.data;
          end
        end else if (valid && pv) begin
          chk("req_hold_data", 64'({write, data}), 64'({1'b1, cur_data}));
        end
        if ((done && !pdone) || (err && !perr)) begin
          if (term_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_term: got done=%0b error=%0b want none (cycle %0d)", done, err, cyc);
          end else begin
            mt = term_q.pop_front();
            chk("term_cycle", 64'(cyc), 64'(mt.cyc));
            chk("term_kind", 64'({err, done}), mt.is_err ? 64'(2) : 64'(1));
            chk("term_step", 64'(step), 64'(mt.step));
            chk("term_valid_busy", 64'({valid, busy}), 64'(0));
          end
        end
      end
      pv    = valid;
      pd    = data;
      pdone = done;
      perr  = err;
    end
  end

  // Reference timing: request k rises at r; transfer at r+a+1; settle exit at transfer+d+1;
  // next request rises wait-cycles after settle exit. Ack missing for TMO cycles ends in error.
  task automatic model(input int s, output int end_c);
    int r, t, x;
    r = s;
    end_c = s;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{cyc: r, data: words[k], step: k});
      if (a_cfg[k] >= TMO) begin
        term_q.push_back('{cyc: r + TMO, is_err: 1'b1, step: k});
        end_c = r + TMO;
        return;
      end
      exp_w.push_back(words[k]);
      t = r + a_cfg[k] + 1;
      if (d_cfg[k] >= TMO) begin
        term_q.push_back('{cyc: t + TMO, is_err: 1'b1, step: k});
        end_c = t + TMO;
        return;
      end
      x = t + d_cfg[k] + 1;
      if (k == 3) begin
        term_q.push_back('{cyc: x, is_err: 1'b0, step: 3});
        end_c = x;
        return;
      end
      r = x + waits[k];
    end
  endtask

  task automatic set_cfg(input int a0, a1, a2, a3, d0, d1, d2, d3);
    a_cfg = '{a0, a1, a2, a3};
    d_cfg = '{d0, d1, d2, d3};
  endtask

  task automatic start_seq(output int s, output int end_c);
    @(negedge clk);
    cap_q.delete();
    exp_w.delete();
    start_i = 1'b1;
    start_cnt++;
    s = cyc + 1;
    model(s, end_c);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic finish_seq();
    chk("requests_left", 64'(exp_q.size()), 64'(0));
    chk("terms_left", 64'(term_q.size()), 64'(0));
    chk("write_count", 64'(cap_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < cap_q.size() && i < exp_w.size(); i++)
      chk("write_data", 64'(cap_q[i]), 64'(exp_w[i]));
    exp_q.delete();
    term_q.delete();
  endtask

  task automatic run_seq(input bit pulse);
    int s, end_c;
    start_seq(s, end_c);
    if (pulse) begin
      repeat (3) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    while (cyc < end_c + 4) @(negedge clk);
    finish_seq();
  endtask

  initial begin
    int s, end_c;
    words = '{32'h0000_0000, 32'h0000_0003, 32'h0000_0023, 32'h0000_002B};
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, err, step, valid, write}), 64'(0));
    chk("reset_bus", 64'({addr, data}), 64'(0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_ctrl", 64'({busy, done, err, step, valid, write}), 64'(0));
    chk("idle_bus", 64'({addr, data}), 64'(0));

    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);     run_seq(1'b0);
    set_cfg(0, 4, 0, 0, 0, 0, 0, 0);     run_seq(1'b0);
    set_cfg(0, 0, 0, 0, 6, 6, 6, 6);     run_seq(1'b0);
    set_cfg(1000, 0, 0, 0, 0, 0, 0, 0);  run_seq(1'b1);
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);     run_seq(1'b0);
    set_cfg(0, 0, 0, 0, 0, 0, 25, 0);    run_seq(1'b1);

    // Asynchronous reset in the middle of the step-1 wait.
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    start_seq(s, end_c);
    while (cyc < s + 12) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'({busy, done, err, step, valid, write}), 64'(0));
    chk("async_reset_bus", 64'({addr, data}), 64'(0));
    exp_q.delete();
    term_q.delete();
    chk("pre_reset_writes", 64'(cap_q.size()), 64'(2));
    for (int i = 0; i < cap_q.size() && i < 2; i++)
      chk("pre_reset_data", 64'(cap_q[i]), 64'(words[i]));
    cap_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b1);

    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 4; k++) begin
        a_cfg[k] = int'($urandom_range(0, 6));
        d_cfg[k] = int'($urandom_range(0, 8));
      end
      run_seq(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
